// File: rtl/gpio_bank_pkg.sv
// Shared register map and constants for the GPIO bank.
// Register offsets sit in the low address bits, and the channel index sits above them.
// The testbench imports the same offsets, so the map is defined only here.
package gpio_bank_pkg;

   localparam int REG_BITS = 3;

   localparam logic [REG_BITS-1:0] REG_OUT  = 3'd0;
   localparam logic [REG_BITS-1:0] REG_SET  = 3'd1;
   localparam logic [REG_BITS-1:0] REG_CLR  = 3'd2;
   localparam logic [REG_BITS-1:0] REG_TGL  = 3'd3;
   localparam logic [REG_BITS-1:0] REG_IN   = 3'd4;
   localparam logic [REG_BITS-1:0] REG_RISE = 3'd5;
   localparam logic [REG_BITS-1:0] REG_FALL = 3'd6;
   localparam logic [REG_BITS-1:0] REG_IEN  = 3'd7;

   // Cycles after reset during which edge capture is held off while the synchroniser fills.
   localparam int PRIME_CYCLES = 2;

endpackage

// File: rtl/gpio_channel.sv
// One GPIO port: output register with set/clear/toggle, input synchroniser, sticky edges, irq.
// Latency: writes land at the strobe edge; a pin change reaches IN after 2 edges, and RISE/FALL after 3.
// Backpressure: none, because the bus accepts one write per cycle unconditionally.
module gpio_channel
   import gpio_bank_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_sel,
   input  logic [REG_BITS-1:0] reg_idx,
   input  logic [WIDTH-1:0]    wdata,
   input  logic                armed,
   input  logic [WIDTH-1:0]    pins,
   output logic [WIDTH-1:0]    out,
   output logic [WIDTH-1:0]    rdata,
   output logic                irq
);

   logic [WIDTH-1:0] sync1, sync2, prev;
   logic [WIDTH-1:0] ien, rise, fall;
   logic [WIDTH-1:0] rise_cap, fall_cap, rise_clr, fall_clr;

   // While unarmed, prev follows sync1 so that it already matches sync2 when
   // detection starts. A pin that was high at reset then shows no edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= pins;
         sync2 <= sync1;
         prev  <= armed ? sync2 : sync1;
      end
   end

   assign rise_cap = armed ? (sync2 & ~prev) : '0;
   assign fall_cap = armed ? (~sync2 & prev) : '0;
   assign rise_clr = (wr_sel && reg_idx == REG_RISE) ? wdata : '0;
   assign fall_clr = (wr_sel && reg_idx == REG_FALL) ? wdata : '0;

   // Sticky edge flags: a capture in the same cycle as a clear keeps the bit set.
   always_ff @(posedge clk) begin
      if (reset) begin
         rise <= '0;
         fall <= '0;
      end else begin
         rise <= (rise & ~rise_clr) | rise_cap;
         fall <= (fall & ~fall_clr) | fall_cap;
      end
   end

   // Output and interrupt-enable registers with atomic set/clear/toggle.
   always_ff @(posedge clk) begin
      if (reset) begin
         out <= '0;
         ien <= '0;
      end else if (wr_sel) begin
         case (reg_idx)
            REG_OUT: out <= wdata;
            REG_SET: out <= out | wdata;
            REG_CLR: out <= out & ~wdata;
            REG_TGL: out <= out ^ wdata;
            REG_IEN: ien <= wdata;
            default: ;
         endcase
      end
   end

   // Read view of this port's registers. Write-only offsets read as zero.
   always_comb begin
      rdata = '0;
      case (reg_idx)
         REG_OUT:  rdata = out;
         REG_IN:   rdata = sync2;
         REG_RISE: rdata = rise;
         REG_FALL: rdata = fall;
         REG_IEN:  rdata = ien;
         default:  rdata = '0;
      endcase
   end

   assign irq = |((rise | fall) & ien);

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped bank of CHANNELS GPIO ports with one combined interrupt.
// Latency: a write lands at its strobe edge, and READ_DATA is registered one cycle after ADDRESS.
// Backpressure: none; the bus takes a single-cycle write or read every cycle.
module gpio_bank
   import gpio_bank_pkg::*;
#(
   parameter int CHANNELS   = 2,
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic [ADDR_WIDTH-1:0]     ADDRESS,
   input  logic [31:0]               WRITE_DATA,
   input  logic                      WRITE_ENABLE,
   output logic [31:0]               READ_DATA,
   output logic [CHANNELS*WIDTH-1:0] GPIO_OUT,
   input  logic [CHANNELS*WIDTH-1:0] GPIO_IN,
   output logic                      IRQ
);

   localparam int CH_W = ADDR_WIDTH - REG_BITS;

   logic [CH_W-1:0]     ch_idx;
   logic [REG_BITS-1:0] reg_idx;
   logic [WIDTH-1:0]    ch_rdata [CHANNELS];
   logic [CHANNELS-1:0] ch_irq;
   logic [31:0]         rd_mux;
   logic [1:0]          prime_cnt;
   logic                armed;

   assign ch_idx  = ADDRESS[ADDR_WIDTH-1:REG_BITS];
   assign reg_idx = ADDRESS[REG_BITS-1:0];
   assign armed   = (prime_cnt == 2'(PRIME_CYCLES));

   // Prime counter: counts the cycles after reset, then stays at the armed value.
   always_ff @(posedge CLK) begin
      if (RESET)       prime_cnt <= '0;
      else if (!armed) prime_cnt <= prime_cnt + 2'd1;
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic sel;
      assign sel = WRITE_ENABLE && (ch_idx == CH_W'(c));

      gpio_channel #(.WIDTH(WIDTH)) u_ch (
         .clk     (CLK),
         .reset   (RESET),
         .wr_sel  (sel),
         .reg_idx (reg_idx),
         .wdata   (WRITE_DATA[WIDTH-1:0]),
         .armed   (armed),
         .pins    (GPIO_IN[c*WIDTH +: WIDTH]),
         .out     (GPIO_OUT[c*WIDTH +: WIDTH]),
         .rdata   (ch_rdata[c]),
         .irq     (ch_irq[c])
      );
   end

   // Select the addressed channel. Out-of-range channels and unused upper bits read zero.
   always_comb begin
      rd_mux = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (ch_idx == CH_W'(c)) rd_mux[WIDTH-1:0] = ch_rdata[c];
      end
   end

   // Registered read port. It samples pre-edge state, so a read that coincides with a write returns the old value.
   always_ff @(posedge CLK) begin
      if (RESET) READ_DATA <= '0;
      else       READ_DATA <= rd_mux;
   end

   assign IRQ = |ch_irq;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed test of gpio_bank with a cycle-tagged scoreboard.
// Stimulus pushes expected values with the cycle in which they are due.
// A negedge monitor pops those entries and compares them against the DUT outputs.
module tb_gpio_bank;
   import gpio_bank_pkg::*;

   localparam int CH = 2;
   localparam int W  = 32;
   localparam int AW = 7;

   localparam int K_RD     = 0;
   localparam int K_OUT0   = 1;
   localparam int K_OUTALL = 2;
   localparam int K_IRQ    = 3;

   typedef struct {
      string       name;
      int          kind;
      logic [63:0] exp;
      int          due;
   } chk_t;

   logic              CLK;
   logic              RESET;
   logic [AW-1:0]     ADDRESS;
   logic [31:0]       WRITE_DATA;
   logic              WRITE_ENABLE;
   logic [31:0]       READ_DATA;
   logic [CH*W-1:0]   GPIO_OUT;
   logic [CH*W-1:0]   GPIO_IN;
   logic              IRQ;

   chk_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   gpio_bank #(.CHANNELS(CH), .WIDTH(W), .ADDR_WIDTH(AW)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .ADDRESS      (ADDRESS),
      .WRITE_DATA   (WRITE_DATA),
      .WRITE_ENABLE (WRITE_ENABLE),
      .READ_DATA    (READ_DATA),
      .GPIO_OUT     (GPIO_OUT),
      .GPIO_IN      (GPIO_IN),
      .IRQ          (IRQ)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   // Monitor: compare every scoreboard entry that has come due.
   always @(negedge CLK) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due <= cyc) begin
            logic [63:0] act;
            case (sb[i].kind)
               K_RD:     act = {32'b0, READ_DATA};
               K_OUT0:   act = {32'b0, GPIO_OUT[31:0]};
               K_OUTALL: act = GPIO_OUT;
               default:  act = {63'b0, IRQ};
            endcase
            checks++;
            if (act !== sb[i].exp) begin
               errors++;
               $display("FAIL %s: got %h expected %h (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
            end
            sb.delete(i);
         end
      end
   end

   function automatic logic [AW-1:0] addr(input int ch, input logic [REG_BITS-1:0] r);
      logic [AW-1:0] a;
      a = AW'(ch << REG_BITS) | AW'(r);
      return a;
   endfunction

   task automatic expect_at(input int kind, input string name, input logic [63:0] exp, input int dly);
      chk_t e;
      e.name = name;
      e.kind = kind;
      e.exp  = exp;
      e.due  = cyc + dly;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input int ch, input logic [REG_BITS-1:0] r, input logic [31:0] d);
      ADDRESS      = addr(ch, r);
      WRITE_DATA   = d;
      WRITE_ENABLE = 1'b1;
      tick();
      WRITE_ENABLE = 1'b0;
      WRITE_DATA   = '0;
   endtask

   task automatic rd(input int ch, input logic [REG_BITS-1:0] r, input logic [31:0] exp, input string name);
      ADDRESS      = addr(ch, r);
      WRITE_ENABLE = 1'b0;
      expect_at(K_RD, name, {32'b0, exp}, 1);
      tick();
   endtask

   // Drive ch1 bit3 and wait until the edge capture edge (the 3rd) has passed.
   task automatic pin3(input logic v);
      GPIO_IN[W+3] = v;
      tick();
      tick();
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET        = 1'b1;
      ADDRESS      = '0;
      WRITE_DATA   = '0;
      WRITE_ENABLE = 1'b0;
      GPIO_IN      = '1;
      repeat (3) tick();
      checks++;
      if (GPIO_OUT !== '0) begin
         errors++;
         $display("FAIL rst_direct_out: got %h expected 0", GPIO_OUT);
      end
      checks++;
      if (READ_DATA !== 32'h0) begin
         errors++;
         $display("FAIL rst_direct_read: got %h expected 0", READ_DATA);
      end
      checks++;
      if (IRQ !== 1'b0) begin
         errors++;
         $display("FAIL rst_direct_irq: got %b expected 0", IRQ);
      end
      expect_at(K_OUTALL, "rst_gpio_out", 64'h0, 0);
      expect_at(K_RD,     "rst_read",     64'h0, 0);
      expect_at(K_IRQ,    "rst_irq",      64'h0, 0);
      RESET = 1'b0;
      repeat (5) tick();

      // Pins were high through reset: no false rise is allowed.
      rd(0, REG_RISE, 32'h0, "prime_rise0");
      rd(1, REG_RISE, 32'h0, "prime_rise1");
      expect_at(K_IRQ, "prime_irq", 64'h0, 0);
      rd(0, REG_IN, 32'hFFFF_FFFF, "in_ch0");
      rd(1, REG_IN, 32'hFFFF_FFFF, "in_ch1");

      // Atomic output operations on ch0.
      expect_at(K_OUT0, "out_write", 64'hF0, 1);
      wr(0, REG_OUT, 32'h0000_00F0);
      expect_at(K_OUT0, "out_set", 64'hFF, 1);
      wr(0, REG_SET, 32'h0000_000F);
      expect_at(K_OUT0, "out_clr", 64'hCF, 1);
      wr(0, REG_CLR, 32'h0000_0030);
      expect_at(K_OUT0, "out_tgl", 64'h1CE, 1);
      wr(0, REG_TGL, 32'h0000_0101);
      rd(0, REG_OUT, 32'h1CE, "rd_out0");
      rd(0, REG_SET, 32'h0, "rd_set_zero");

      // A read coinciding with a write returns the pre-write value.
      expect_at(K_RD, "rd_during_wr", 64'h1CE, 1);
      expect_at(K_OUT0, "out_overwrite", 64'h55, 1);
      wr(0, REG_OUT, 32'h0000_0055);
      expect_at(K_OUTALL, "out_pack", 64'h1234_5678_0000_0055, 1);
      wr(1, REG_OUT, 32'h1234_5678);
      wr(0, REG_IN, 32'h0);
      rd(0, REG_IN, 32'hFFFF_FFFF, "in_write_ignored");

      // Falling edges on ch1 with interrupts disabled.
      GPIO_IN[2*W-1:W] = '0;
      repeat (4) tick();
      rd(1, REG_FALL, 32'hFFFF_FFFF, "fall_all");
      expect_at(K_IRQ, "irq_masked", 64'h0, 0);
      wr(1, REG_FALL, 32'hFFFF_FFFF);
      rd(1, REG_FALL, 32'h0, "fall_w1c");
      wr(1, REG_IEN, 32'h8);
      rd(1, REG_IEN, 32'h8, "ien_rd");

      // A rise on ch1 bit3 sets RISE and IRQ on the 3rd edge, and a W1C drops IRQ.
      expect_at(K_IRQ, "irq_not_yet", 64'h0, 2);
      expect_at(K_IRQ, "irq_rise", 64'h1, 3);
      pin3(1'b1);
      rd(1, REG_RISE, 32'h8, "rise_bit3");
      expect_at(K_IRQ, "irq_hold", 64'h1, 0);
      expect_at(K_IRQ, "irq_w1c_drop", 64'h0, 1);
      wr(1, REG_RISE, 32'h8);

      // Build RISE=1 with FALL cleared, then collide a new capture with the W1C.
      pin3(1'b0);
      wr(1, REG_FALL, 32'h8);
      pin3(1'b1);
      pin3(1'b0);
      expect_at(K_IRQ, "irq_rise_pending", 64'h1, 1);
      wr(1, REG_FALL, 32'h8);
      GPIO_IN[W+3] = 1'b1;
      tick();
      tick();
      expect_at(K_IRQ, "irq_capture_wins", 64'h1, 1);
      wr(1, REG_RISE, 32'h8);
      rd(1, REG_RISE, 32'h8, "rise_capture_wins");

      // Out-of-range channel index.
      expect_at(K_OUTALL, "oor_no_write", 64'h1234_5678_0000_0055, 1);
      wr(CH, REG_OUT, 32'hDEAD_BEEF);
      rd(CH, REG_OUT, 32'h0, "oor_read");

      // Reset mid-operation, one cycle after a toggle, with IRQ pending.
      expect_at(K_IRQ, "irq_before_rst", 64'h1, 0);
      expect_at(K_OUT0, "tgl_before_rst", 64'hAA, 1);
      wr(0, REG_TGL, 32'h0000_00FF);
      RESET = 1'b1;
      expect_at(K_OUTALL, "rst_mid_out", 64'h0, 1);
      expect_at(K_IRQ,    "rst_mid_irq", 64'h0, 1);
      expect_at(K_RD,     "rst_mid_read", 64'h0, 1);
      tick();
      RESET = 1'b0;
      rd(0, REG_OUT,  32'h0, "rst_out0");
      rd(1, REG_OUT,  32'h0, "rst_out1");
      rd(1, REG_IEN,  32'h0, "rst_ien1");
      rd(1, REG_FALL, 32'h0, "rst_fall1");
      repeat (4) tick();
      rd(1, REG_RISE, 32'h0, "rst_rise1_primed");
      rd(0, REG_RISE, 32'h0, "rst_rise0_primed");
      expect_at(K_IRQ, "rst_irq_late", 64'h0, 0);
      repeat (3) tick();

      foreach (sb[i]) begin
         errors++;
         $display("FAIL %s: got never-checked expected %h", sb[i].name, sb[i].exp);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
